// File: rtl/drr_pkg.sv
`default_nettype none
// ============================================================================
// drr_pkg : shared types and constants for the DRR scheduler and queue bank
// Revision: 1.0
// ============================================================================
package drr_pkg;

    localparam int SIZE_W               = 16;
    localparam int DEFAULT_MAX_PKT_SIZE = 1518;

    typedef logic [SIZE_W-1:0] pkt_size_t;

    // Flow-ID width; a single flow still needs a 1-bit select
    function automatic int qid_w(input int pkt_qs_cnt);
        return (pkt_qs_cnt > 1) ? $clog2(pkt_qs_cnt) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_size_fifo.sv
`default_nettype none
// ============================================================================
// pkt_size_fifo : single-flow first-word-fall-through FIFO of packet sizes
// Revision: 1.0
// ============================================================================
module pkt_size_fifo
    import drr_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  pkt_size_t              data_i,
    input  logic                   pop_i,
    output pkt_size_t              head_o,
    output logic                   not_empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    pkt_size_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
    assign not_empty_o = (count_q != '0);
    assign count_o     = count_q;
    assign w_push      = push_i && !full_o;
    assign w_pop       = pop_i && not_empty_o;
    // Stale slots are masked so an empty flow always presents a zero head
    assign head_o      = not_empty_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/pkt_queue_bank.sv
`default_nettype none
// ============================================================================
// pkt_queue_bank : per-flow packet-size queues feeding the DRR scheduler
// Revision: 1.0
// ============================================================================
module pkt_queue_bank
    import drr_pkg::*;
#(
    parameter int PKT_QS_CNT   = 4,
    parameter int QUEUE_DEPTH  = 16,
    parameter int MAX_PKT_SIZE = DEFAULT_MAX_PKT_SIZE
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic                                          enq_val_i,
    input  logic [qid_w(PKT_QS_CNT)-1:0]                  enq_qid_i,
    input  logic [SIZE_W-1:0]                             enq_size_i,
    output logic                                          enq_rdy_o,
    output logic [PKT_QS_CNT*SIZE_W-1:0]                  size_o,
    output logic [PKT_QS_CNT-1:0]                         size_val_o,
    input  logic [qid_w(PKT_QS_CNT)-1:0]                  read_i,
    input  logic                                          read_val_i,
    output logic                                          out_val_o,
    output logic [qid_w(PKT_QS_CNT)-1:0]                  out_qid_o,
    output logic [SIZE_W-1:0]                             out_size_o,
    output logic [PKT_QS_CNT*($clog2(QUEUE_DEPTH)+1)-1:0] fill_o,
    output logic [31:0]                                   drop_cnt_o,
    output logic                                          pop_err_o
);

    localparam int QID_W = qid_w(PKT_QS_CNT);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    pkt_size_t              w_head [PKT_QS_CNT];
    logic [PKT_QS_CNT-1:0]  w_not_empty;
    logic [PKT_QS_CNT-1:0]  w_full;
    logic [PKT_QS_CNT-1:0]  w_push;
    logic [PKT_QS_CNT-1:0]  w_pop;
    logic                   w_size_ok;
    logic                   w_enq_fire;
    logic                   w_pop_hit;
    logic                   w_pop_miss;

    logic                   out_val_q;
    logic [QID_W-1:0]       out_qid_q;
    pkt_size_t              out_size_q;
    logic [31:0]            drop_cnt_q;
    logic [31:0]            drop_cnt_d;
    logic                   pop_err_q;

    // Ready depends only on the target flow's fill, never on this cycle's pop
    assign enq_rdy_o  = !w_full[enq_qid_i];
    assign w_enq_fire = enq_val_i && enq_rdy_o;
    assign w_size_ok  = (enq_size_i != '0) && (enq_size_i <= SIZE_W'(MAX_PKT_SIZE));
    assign w_pop_hit  = read_val_i && w_not_empty[read_i];
    assign w_pop_miss = read_val_i && !w_not_empty[read_i];

    generate
        for (genvar g = 0; g < PKT_QS_CNT; g++) begin : g_flow
            assign w_push[g] = w_enq_fire && w_size_ok && (enq_qid_i == QID_W'(g));
            assign w_pop[g]  = read_val_i && (read_i == QID_W'(g));

            pkt_size_fifo #(
                .DEPTH       (QUEUE_DEPTH)
            ) u_fifo (
                .clk_i       (clk_i),
                .rst_n_i     (rst_n_i),
                .push_i      (w_push[g]),
                .data_i      (enq_size_i),
                .pop_i       (w_pop[g]),
                .head_o      (w_head[g]),
                .not_empty_o (w_not_empty[g]),
                .full_o      (w_full[g]),
                .count_o     (fill_o[g*CNT_W +: CNT_W])
            );

            assign size_o[g*SIZE_W +: SIZE_W] = w_head[g];
            assign size_val_o[g]              = w_not_empty[g];
        end
    endgenerate

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_enq_fire && !w_size_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_val_q  <= 1'b0;
            out_qid_q  <= '0;
            out_size_q <= '0;
            drop_cnt_q <= '0;
            pop_err_q  <= 1'b0;
        end else begin
            out_val_q  <= w_pop_hit;
            if (w_pop_hit) begin
                out_qid_q  <= read_i;
                out_size_q <= w_head[read_i];
            end
            drop_cnt_q <= drop_cnt_d;
            if (w_pop_miss) pop_err_q <= 1'b1;
        end
    end

    assign out_val_o  = out_val_q;
    assign out_qid_o  = out_qid_q;
    assign out_size_o = out_size_q;
    assign drop_cnt_o = drop_cnt_q;
    assign pop_err_o  = pop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_queue_bank.sv
`default_nettype none
// ============================================================================
// tb_pkt_queue_bank : self-checking bench with per-flow model and output scoreboard
// Revision: 1.0
// ============================================================================
module tb_pkt_queue_bank;

    localparam int NQ    = 4;
    localparam int DEPTH = 16;
    localparam int MAXSZ = 1518;
    localparam int CW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enq_val_i;
    logic [1:0]      enq_qid_i;
    logic [15:0]     enq_size_i;
    logic            enq_rdy_o;
    logic [NQ*16-1:0] size_o;
    logic [NQ-1:0]   size_val_o;
    logic [1:0]      read_i;
    logic            read_val_i;
    logic            out_val_o;
    logic [1:0]      out_qid_o;
    logic [15:0]     out_size_o;
    logic [NQ*CW-1:0] fill_o;
    logic [31:0]     drop_cnt_o;
    logic            pop_err_o;

    always #5 clk = ~clk;

    pkt_queue_bank #(
        .PKT_QS_CNT   (NQ),
        .QUEUE_DEPTH  (DEPTH),
        .MAX_PKT_SIZE (MAXSZ)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .enq_val_i  (enq_val_i),
        .enq_qid_i  (enq_qid_i),
        .enq_size_i (enq_size_i),
        .enq_rdy_o  (enq_rdy_o),
        .size_o     (size_o),
        .size_val_o (size_val_o),
        .read_i     (read_i),
        .read_val_i (read_val_i),
        .out_val_o  (out_val_o),
        .out_qid_o  (out_qid_o),
        .out_size_o (out_size_o),
        .fill_o     (fill_o),
        .drop_cnt_o (drop_cnt_o),
        .pop_err_o  (pop_err_o)
    );

    typedef struct {
        int qid;
        int sz;
    } exp_t;

    typedef struct {
        bit        ev;
        bit [1:0]  q;
        bit [15:0] sz;
        bit        rv;
        bit [1:0]  rq;
        bit        exp_rdy;
        bit [3:0]  exp_sval;
        int        exp_drop;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   mq [NQ][$];
    int   drop_m;
    bit   perr_m;
    exp_t expq [$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Each expected departure must appear exactly one cycle after its pop edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("out_val", out_val_o, 1);
                chk("out_qid", out_qid_o, mon_e.qid);
                chk("out_size", out_size_o, mon_e.sz);
            end else begin
                chk("out_val idle", out_val_o, 0);
            end
        end
    end

    task automatic check_model();
        for (int f = 0; f < NQ; f++) begin
            chk($sformatf("size_val[%0d]", f), size_val_o[f], mq[f].size() > 0);
            chk($sformatf("size[%0d]", f), size_o[f*16 +: 16], (mq[f].size() > 0) ? mq[f][0] : 0);
            chk($sformatf("fill[%0d]", f), fill_o[f*CW +: CW], mq[f].size());
        end
        chk("drop_cnt", drop_cnt_o, drop_m);
        chk("pop_err", pop_err_o, perr_m);
    endtask

    task automatic clear_model();
        for (int f = 0; f < NQ; f++) mq[f].delete();
        drop_m = 0;
        perr_m = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the next one
    task automatic step(input bit ev, input bit [1:0] q, input bit [15:0] sz,
                        input bit rv, input bit [1:0] rq);
        bit   rdy;
        bit   have_pop;
        exp_t e;
        enq_val_i  = ev;
        enq_qid_i  = q;
        enq_size_i = sz;
        read_val_i = rv;
        read_i     = rq;
        @(negedge clk);
        rdy = mq[q].size() < DEPTH;
        chk("enq_rdy", enq_rdy_o, rdy);
        have_pop = 1'b0;
        if (rv) begin
            if (mq[rq].size() > 0) begin
                e.qid    = rq;
                e.sz     = mq[rq].pop_front();
                have_pop = 1'b1;
            end else begin
                perr_m = 1'b1;
            end
        end
        if (ev && rdy) begin
            if (sz == 0 || sz > MAXSZ) drop_m++;
            else mq[q].push_back(sz);
        end
        @(posedge clk);
        #1;
        if (have_pop) expq.push_back(e);
        enq_val_i  = 1'b0;
        read_val_i = 1'b0;
        check_model();
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        enq_val_i  = 1'b0;
        read_val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        chk("rst size_val", size_val_o, 0);
        chk("rst fill", fill_o, 0);
        chk("rst size", size_o[31:0], 0);
        chk("rst out_val", out_val_o, 0);
        chk("rst out_qid", out_qid_o, 0);
        chk("rst out_size", out_size_o, 0);
        chk("rst drop", drop_cnt_o, 0);
        chk("rst pop_err", pop_err_o, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        enq_qid_i  = '0;
        enq_size_i = '0;
        read_i     = '0;
        vecs[0] = '{1'b1, 2'd2, 16'd300,  1'b0, 2'd0, 1'b1, 4'b0100, 0};
        vecs[1] = '{1'b1, 2'd1, 16'd0,    1'b0, 2'd0, 1'b1, 4'b0100, 1};
        vecs[2] = '{1'b1, 2'd1, 16'd1600, 1'b0, 2'd0, 1'b1, 4'b0100, 2};
        vecs[3] = '{1'b1, 2'd3, 16'd200,  1'b0, 2'd0, 1'b1, 4'b1100, 2};
        vecs[4] = '{1'b1, 2'd3, 16'd400,  1'b0, 2'd0, 1'b1, 4'b1100, 2};
        vecs[5] = '{1'b0, 2'd0, 16'd0,    1'b1, 2'd3, 1'b1, 4'b1100, 2};
        vecs[6] = '{1'b0, 2'd0, 16'd0,    1'b1, 2'd3, 1'b1, 4'b0100, 2};
        vecs[7] = '{1'b1, 2'd1, 16'd64,   1'b1, 2'd1, 1'b1, 4'b0110, 2};
        vecs[8] = '{1'b0, 2'd0, 16'd0,    1'b1, 2'd2, 1'b1, 4'b0010, 2};

        apply_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            enq_qid_i = vecs[i].q;
            #1;
            chk($sformatf("vec%0d rdy", i), enq_rdy_o, vecs[i].exp_rdy);
            step(vecs[i].ev, vecs[i].q, vecs[i].sz, vecs[i].rv, vecs[i].rq);
            chk($sformatf("vec%0d sval", i), size_val_o, vecs[i].exp_sval);
            chk($sformatf("vec%0d drop", i), drop_cnt_o, vecs[i].exp_drop);
        end
        chk("empty pop sets err", pop_err_o, 1);
        chk("same-cycle push kept", size_o[16 +: 16], 64);

        // Full flow: 17th entry blocked, then accepted the cycle after a pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, 16'(100 + i), 1'b0, 2'd0);
        enq_qid_i = 2'd0;
        #1;
        chk("flow0 full rdy", enq_rdy_o, 0);
        enq_qid_i = 2'd1;
        #1;
        chk("flow1 rdy", enq_rdy_o, 1);
        step(1'b1, 2'd0, 16'd116, 1'b1, 2'd0);
        step(1'b1, 2'd0, 16'd116, 1'b0, 2'd0);
        chk("flow0 refilled", fill_o[0 +: CW], 16);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 2'd0, 16'd0, 1'b1, 2'd0);

        // Reset mid-operation discards stored descriptors
        step(1'b1, 2'd2, 16'd77, 1'b0, 2'd0);
        step(1'b1, 2'd1, 16'd88, 1'b0, 2'd0);
        apply_reset();
        check_model();

        for (int i = 0; i < 300; i++) begin
            bit [15:0] sz;
            case ($urandom_range(0, 7))
                0:       sz = 16'd0;
                1:       sz = 16'd1519;
                2:       sz = 16'd1518;
                3:       sz = 16'd1;
                default: sz = 16'($urandom_range(1, MAXSZ));
            endcase
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), sz,
                 ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
